// File: rtl/stdp_pkg.sv
// -----------------------------------------------------------------------------
// stdp_pkg
// Shared definitions for the STDP weight datapath.
//   LANES           : number of lanes in a weight frame
//   SEL_W           : width of a lane index
//   scatter_state_t : occupancy state of the write-side scatter bank
// The lane word type depends on WIDTH, so modules that need it declare it
// locally from their own WIDTH parameter.
// -----------------------------------------------------------------------------
package stdp_pkg;

    localparam int LANES = 16;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL
    } scatter_state_t;

endpackage

// File: rtl/weight_scatter_bank.sv
// -----------------------------------------------------------------------------
// weight_scatter_bank
// Write-side counterpart of the 16:1 weight selection mux. Accepts WIDTH-bit
// synaptic words over a valid/ready handshake and scatters them into a 16-lane
// register bank. The target lane comes from an auto-incrementing pointer or
// from an explicit select. Once every lane holds fresh data the frame is
// presented and held until the consumer acknowledges it.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset
//   in_valid   : producer offers a word
//   in_ready   : bank can take a word this cycle (state decode, gated by reset)
//   in_data    : word to store
//   in_mode    : 0 = lane from write pointer, 1 = lane from in_sel
//   in_sel     : explicit lane when in_mode = 1
//   clear      : abort current frame (lane data kept)
//   out        : registered lane contents, lanes 0..15
//   lane_valid : per-lane "written in this frame" flags
//   out_valid  : complete frame present
//   out_ack    : consumer releases the frame
// -----------------------------------------------------------------------------
module weight_scatter_bank
    import stdp_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             clear,
    output logic [WIDTH-1:0] out [0:LANES-1],
    output logic [LANES-1:0] lane_valid,
    output logic             out_valid,
    input  logic             out_ack
);

    typedef logic [WIDTH-1:0] lane_word_t;

    scatter_state_t   r_state;
    scatter_state_t   w_stateNext;
    lane_word_t       r_out [0:LANES-1];
    logic [LANES-1:0] r_laneValid;
    logic [SEL_W-1:0] r_wrPtr;
    logic             r_outValid;

    logic             w_accept;
    logic [SEL_W-1:0] w_lane;
    logic [LANES-1:0] w_wrOnehot;
    logic             w_allValid;
    logic             w_release;

    // Ready is a pure state decode so the producer never sees a combinational
    // path from its own valid; it is forced low while reset is held.
    assign in_ready = (r_state != FULL) && rst_n;
    assign w_accept = in_valid && in_ready;

    // Lane decode: one-hot write enable, all zeros when no beat is taken.
    assign w_lane     = in_mode ? in_sel : r_wrPtr;
    assign w_wrOnehot = w_accept ? (LANES'(1) << w_lane) : '0;
    assign w_allValid = ((r_laneValid | w_wrOnehot) == '1);
    assign w_release  = (r_state == FULL) && out_ack;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic. Clear overrides everything; ack only matters in FULL.
    always_comb begin
        w_stateNext = r_state;
        if (clear) begin
            w_stateNext = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_stateNext = w_allValid ? FULL : FILLING;
                    end
                end
                FILLING: begin
                    if (w_accept && w_allValid) begin
                        w_stateNext = FULL;
                    end
                end
                FULL: begin
                    if (out_ack) begin
                        w_stateNext = EMPTY;
                    end
                end
                default: w_stateNext = EMPTY;
            endcase
        end
    end

    // Frame bookkeeping and lane storage. Clear and ack both drop the frame
    // flags and rewind the pointer but leave the lane words in place, so the
    // downstream mux keeps seeing the last data until it is overwritten.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_laneValid <= '0;
            r_wrPtr     <= '0;
            r_outValid  <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_out[i] <= '0;
            end
        end else begin
            r_outValid <= (w_stateNext == FULL);
            if (clear || w_release) begin
                r_laneValid <= '0;
                r_wrPtr     <= '0;
            end else if (w_accept) begin
                r_laneValid <= r_laneValid | w_wrOnehot;
                if (!in_mode) begin
                    r_wrPtr <= r_wrPtr + SEL_W'(1);
                end
                for (int i = 0; i < LANES; i++) begin
                    if (w_wrOnehot[i]) begin
                        r_out[i] <= in_data;
                    end
                end
            end
        end
    end

    assign out        = r_out;
    assign lane_valid = r_laneValid;
    assign out_valid  = r_outValid;

endmodule

// File: tb/tb_weight_scatter_bank.sv
// -----------------------------------------------------------------------------
// tb_weight_scatter_bank
// Self-checking bench for weight_scatter_bank. A behavioural model of the bank
// (plain arrays: lane words, a set of written lanes, a pointer and a "frame
// held" flag) is advanced on every rising edge from the inputs present at that
// edge, and a compare process checks every DUT output against it one time unit
// later. Directed scenarios pin the model with hand-computed literals, then a
// randomized phase exercises mixed modes, clears, acks and resets.
// -----------------------------------------------------------------------------
module tb_weight_scatter_bank;

    localparam int W = 16;
    localparam int N = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_mode;
    logic [3:0]    in_sel;
    logic          clear;
    logic [W-1:0]  outBus [0:N-1];
    logic [N-1:0]  lane_valid;
    logic          out_valid;
    logic          out_ack;

    int checks = 0;
    int errors = 0;
    bit checkOn = 1'b0;

    // Behavioural model state.
    logic [W-1:0] mOut [0:N-1];
    bit           mWritten [0:N-1];
    int           mPtr;
    bit           mHeld;

    weight_scatter_bank #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_mode    (in_mode),
        .in_sel     (in_sel),
        .clear      (clear),
        .out        (outBus),
        .lane_valid (lane_valid),
        .out_valid  (out_valid),
        .out_ack    (out_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] modelMask();
        logic [N-1:0] m = '0;
        for (int i = 0; i < N; i++) m[i] = mWritten[i];
        return m;
    endfunction

    function automatic int modelCount();
        int c = 0;
        for (int i = 0; i < N; i++) c += mWritten[i] ? 1 : 0;
        return c;
    endfunction

    task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Model: advance on each rising edge using the inputs held at that edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                mOut[i] = '0;
                mWritten[i] = 1'b0;
            end
            mPtr  = 0;
            mHeld = 1'b0;
        end else if (clear) begin
            for (int i = 0; i < N; i++) mWritten[i] = 1'b0;
            mPtr  = 0;
            mHeld = 1'b0;
        end else if (mHeld) begin
            if (out_ack) begin
                for (int i = 0; i < N; i++) mWritten[i] = 1'b0;
                mPtr  = 0;
                mHeld = 1'b0;
            end
        end else if (in_valid) begin
            int lane;
            lane = in_mode ? int'(in_sel) : mPtr;
            mOut[lane]     = in_data;
            mWritten[lane] = 1'b1;
            if (!in_mode) mPtr = (mPtr + 1) % N;
            if (modelCount() == N) mHeld = 1'b1;
        end
        #1;
        if (checkOn) checkOutput();
    end

    task automatic checkOutput();
        compareVal("out_valid", 32'(out_valid), 32'(mHeld));
        compareVal("in_ready", 32'(in_ready), 32'(!mHeld && rst_n));
        compareVal("lane_valid", 32'(lane_valid), 32'(modelMask()));
        for (int i = 0; i < N; i++) begin
            compareVal($sformatf("out[%0d]", i), 32'(outBus[i]), 32'(mOut[i]));
        end
    endtask

    // Drive one cycle of inputs at the falling edge.
    task automatic applyStimulus(input bit rst, input bit v, input bit m, input logic [3:0] s,
                                 input logic [W-1:0] d, input bit c, input bit a);
        @(negedge clk);
        rst_n    = rst;
        in_valid = v;
        in_mode  = m;
        in_sel   = s;
        in_data  = d;
        clear    = c;
        out_ack  = a;
    endtask

    task automatic idle();
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_sel = '0;
        in_data = '0; clear = 1'b0; out_ack = 1'b0;

        // Reset
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, '0, 1'b0, 1'b0);
        checkOn = 1'b1;
        idle();
        #1;
        compareVal("pin reset lane_valid", 32'(lane_valid), 32'h0);
        compareVal("pin reset in_ready", 32'(in_ready), 32'h1);

        // Auto fill, back to back
        for (int i = 0; i < N; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, W'(16'h1000 + i), 1'b0, 1'b0);
            #1;
            if (i == 15) compareVal("pin out_valid before last edge", 32'(out_valid), 32'h0);
        end
        // Backpressure: valid held high through FULL
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 16'hDEAD, 1'b0, 1'b0);
            #1;
            compareVal("pin full out_valid", 32'(out_valid), 32'h1);
            compareVal("pin full in_ready", 32'(in_ready), 32'h0);
        end
        compareVal("pin out[5]", 32'(outBus[5]), 32'h1005);
        compareVal("pin out[15]", 32'(outBus[15]), 32'h100F);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 16'hDEAD, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 16'h5555, 1'b0, 1'b0);
        #1;
        compareVal("pin ack lane_valid", 32'(lane_valid), 32'h0);
        compareVal("pin ack out_valid", 32'(out_valid), 32'h0);
        compareVal("pin ack in_ready", 32'(in_ready), 32'h1);
        compareVal("pin ack retain out[3]", 32'(outBus[3]), 32'h1003);
        idle();
        #1;
        compareVal("pin first beat lane0", 32'(outBus[0]), 32'h5555);
        compareVal("pin first beat mask", 32'(lane_valid), 32'h0001);

        // Addressed out-of-order fill with a late duplicate to lane 3
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, '0, 1'b1, 1'b0);
        for (int l = 15; l >= 0; l--) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 4'(l), W'(16'hA000 | l), 1'b0, 1'b0);
            if (l == 3) applyStimulus(1'b1, 1'b1, 1'b1, 4'd3, 16'hBEEF, 1'b0, 1'b0);
        end
        #1;
        compareVal("pin addr out_valid before last", 32'(out_valid), 32'h0);
        idle();
        #1;
        compareVal("pin addr out_valid", 32'(out_valid), 32'h1);
        compareVal("pin addr out[3]", 32'(outBus[3]), 32'hBEEF);
        compareVal("pin addr out[0]", 32'(outBus[0]), 32'hA000);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, '0, 1'b0, 1'b1);

        // Mixed modes
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, W'(16'hC000 + i), 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd9, 16'hC009, 1'b0, 1'b0);
        for (int i = 3; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, W'(16'hC000 + i), 1'b0, 1'b0);
        idle();
        #1;
        compareVal("pin mixed mask", 32'(lane_valid), 32'h021F);
        compareVal("pin mixed out[4]", 32'(outBus[4]), 32'hC004);

        // Clear colliding with a beat to lane 7, then a spurious ack
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd7, 16'h7777, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, '0, 1'b0, 1'b1);
        #1;
        compareVal("pin clear mask", 32'(lane_valid), 32'h0);
        compareVal("pin clear out[7]", 32'(outBus[7]), 32'hA007);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 16'h0123, 1'b0, 1'b0);
        idle();
        #1;
        compareVal("pin post-clear ptr lane0", 32'(outBus[0]), 32'h0123);
        compareVal("pin spurious ack mask", 32'(lane_valid), 32'h0001);

        // Reset mid-frame
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, W'(16'h2000 + i), 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 16'hFFFF, 1'b0, 1'b0);
        #1;
        compareVal("pin in_ready during reset", 32'(in_ready), 32'h0);
        idle();
        #1;
        compareVal("pin reset out[2]", 32'(outBus[2]), 32'h0);
        compareVal("pin reset in_ready after", 32'(in_ready), 32'h1);

        // Randomized phase
        for (int k = 0; k < 3000; k++) begin
            bit r, v, m, c, a;
            r = ($urandom_range(0, 199) != 0);
            v = ($urandom_range(0, 3) != 0);
            m = ($urandom_range(0, 2) == 0);
            c = ($urandom_range(0, 59) == 0);
            a = ($urandom_range(0, 3) == 0);
            applyStimulus(r, v, m, 4'($urandom_range(0, 15)), W'($urandom), c, a);
        end
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
